// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the cpu core and its program sequencer.
//   - 9-bit instruction format {opcode[2:0], rx[2:0], ry[2:0]}
//   - opcode and register-field encodings
//   - sequencer state enum
//   - fixed program image of {instruction[8:0], data_var[15:0]} entries
package cpu_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  localparam logic [2:0] R0 = 3'd0;
  localparam logic [2:0] R1 = 3'd1;
  localparam logic [2:0] R2 = 3'd2;
  localparam logic [2:0] R3 = 3'd3;
  localparam logic [2:0] R4 = 3'd4;
  localparam logic [2:0] R5 = 3'd5;
  localparam logic [2:0] R6 = 3'd6;
  localparam logic [2:0] R7 = 3'd7;

  localparam int IMAGE_LEN = 16;
  localparam int IMAGE_AW  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_GAP,
    S_FINISHED,
    S_FAULT
  } seq_state_t;

  // Each entry: {opcode, rx, ry, data_var}
  localparam logic [24:0] PROG_IMAGE [IMAGE_LEN] = '{
    {OP_MVI, R0, R0, 16'h0005},
    {OP_MVI, R1, R0, 16'h0003},
    {OP_ADD, R0, R1, 16'h0000},
    {OP_SUB, R0, R1, 16'h0000},
    {OP_MV,  R2, R0, 16'h0000},
    {OP_MVI, R3, R0, 16'h00ff},
    {OP_ADD, R2, R3, 16'h0000},
    {OP_MV,  R4, R2, 16'h0000},
    {OP_MVI, R5, R0, 16'h1234},
    {OP_SUB, R5, R4, 16'h0000},
    {OP_MV,  R6, R5, 16'h0000},
    {OP_MVI, R7, R0, 16'h8000},
    {OP_ADD, R7, R6, 16'h0000},
    {OP_MV,  R1, R7, 16'h0000},
    {OP_SUB, R1, R1, 16'h0000},
    {OP_MVI, R0, R0, 16'h0000}
  };

  // Combinational image lookup.
  function automatic logic [24:0] prog_entry(input logic [IMAGE_AW-1:0] idx);
    return PROG_IMAGE[idx];
  endfunction

endpackage

// File: rtl/edge_detect.sv
// edge_detect: registers a level input and reports its 0->1 transition.
//   clk, rst_n : clock, async active-low reset (history register resets to 0)
//   sig        : level input
//   rise       : high in the cycle where sig=1 and the registered copy is 0
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig;
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: issues (instruction, data_var) pairs from the fixed
// program image to the cpu core, one at a time, over a start/done handshake.
//   clk, rst_n       : clock, async active-low reset
//   run              : level, issue continuously while high
//   step             : pulse, issue one instruction from IDLE
//   cpu_done         : core completion level, only its rising edge counts
//   instruction      : 9-bit instruction presented to the core
//   data_var         : 16-bit immediate presented to the core
//   cpu_start        : one-cycle issue pulse
//   pc               : index of the entry being presented
//   busy             : high from cpu_start until the matching done edge
//   prog_done        : high once the program has finished (LOOP=0)
//   fault            : sticky done-timeout flag
//   state_dbg        : current FSM state
//
// Handshake: cpu_start is high for exactly one cycle (state ISSUE) with
// instruction/data_var already stable; they stay stable until the core
// answers with a 0->1 transition on cpu_done. A done level that is already
// high when an instruction is issued is not an answer; a fresh rising edge
// is required. No new cpu_start is issued before that edge arrives.
module program_sequencer
  import cpu_pkg::*;
#(
  parameter int PROG_LEN = 16,    // at most IMAGE_LEN entries
  parameter int TIMEOUT  = 64,
  parameter bit LOOP     = 1'b0,
  localparam int PCW     = (PROG_LEN > 1) ? $clog2(PROG_LEN) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  input  logic            step,
  input  logic            cpu_done,
  output logic [8:0]      instruction,
  output logic [15:0]     data_var,
  output logic            cpu_start,
  output logic [PCW-1:0]  pc,
  output logic            busy,
  output logic            prog_done,
  output logic            fault,
  output seq_state_t      state_dbg
);

  localparam logic [PCW-1:0] PC_LAST  = PCW'(PROG_LEN - 1);
  localparam int             TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);

  seq_state_t    state;
  logic [TW-1:0] tmo_cnt;
  logic          at_end;
  logic          done_rise;

  edge_detect u_done_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .sig  (cpu_done),
    .rise (done_rise)
  );

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= S_IDLE;
      pc                      <= '0;
      {instruction, data_var} <= prog_entry('0);
      cpu_start               <= 1'b0;
      busy                    <= 1'b0;
      prog_done               <= 1'b0;
      fault                   <= 1'b0;
      tmo_cnt                 <= '0;
      at_end                  <= 1'b0;
    end else begin
      // Image register tracks pc with one cycle of lag; pc only moves on
      // entry to GAP, so the pair is refreshed exactly as ISSUE begins.
      {instruction, data_var} <= prog_entry(IMAGE_AW'(pc));
      cpu_start               <= 1'b0;

      // Outputs of ISSUE/GAP/FINISHED/FAULT are set on entry so they are
      // visible during the state itself.
      case (state)
        S_IDLE: begin
          if (run || step) begin
            state     <= S_ISSUE;
            cpu_start <= 1'b1;
            busy      <= 1'b1;
            tmo_cnt   <= '0;
          end
        end

        // The timeout counter starts in ISSUE so that fault rises exactly
        // TIMEOUT cycles after cpu_start.
        S_ISSUE: begin
          state   <= S_WAIT_DONE;
          tmo_cnt <= tmo_cnt + 1'b1;
        end

        S_WAIT_DONE: begin
          if (done_rise) begin
            state  <= S_GAP;
            busy   <= 1'b0;
            at_end <= (pc == PC_LAST) && !LOOP;
            if (pc == PC_LAST) begin
              if (LOOP) pc <= '0;
            end else begin
              pc <= pc + 1'b1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            state <= S_FAULT;
            fault <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_GAP: begin
          if (at_end) begin
            state     <= S_FINISHED;
            prog_done <= 1'b1;
          end else if (run) begin
            state     <= S_ISSUE;
            cpu_start <= 1'b1;
            busy      <= 1'b1;
            tmo_cnt   <= '0;
          end else begin
            state <= S_IDLE;
          end
        end

        S_FINISHED, S_FAULT: begin
          state <= state;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
